b16_bus_arbiter: RTL and testbench
==================================

Name: b16_bus_arbiter

Overview:
- Shares one single-port memory bus between the b16 CPU and a second bus master: a host, DMA engine or debug loader.
- Stalls the CPU through its run input whenever the host owns the bus or memory inserts wait states.
- Bounds host bursts so the CPU cannot starve.
- Enforces a wait-state timeout that reports a bus error instead of hanging.

Parameters:
- l, 16, data/address width
- HOST_BURST, 4, maximum consecutive completed host accesses before the CPU must get one access (1..15)
- WAIT_MAX, 15, wait-state cycles before forced completion; 0 disables the timeout (0..255)

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_en  in  1  CPU allowed to run (debugger run request)
- cpu_addr  in  l  CPU byte address
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  2  CPU byte write strobes {hi, lo}
- cpu_wdata  in  l  CPU write data
- cpu_data  out  l  read data to CPU
- cpu_run  out  1  CPU run/advance enable
- h_req  in  1  host request, held with its fields until h_ack
- h_addr  in  l  host address
- h_rd  in  1  host read
- h_wr  in  2  host byte write strobes
- h_wdata  in  l  host write data
- h_ack  out  1  host access completes this cycle
- h_rdata  out  l  host read data, valid with h_ack
- mem_addr  out  l  memory address
- mem_rd  out  1  memory read strobe
- mem_wr  out  2  memory byte write strobes
- mem_wdata  out  l  memory write data
- mem_rdata  in  l  memory read data, combinational, valid when mem_ready
- mem_ready  in  1  memory completes the current access this cycle
- bus_err  out  1  one-cycle registered pulse after a timed-out access
- owner  out  1  0 = CPU owns the bus, 1 = host owns it

Behaviour:
- State: owner register, burst counter bcnt (4 bits), wait counter wcnt (8 bits), bus_err register.
- Reset values: owner=0, bcnt=0, wcnt=0, bus_err=0.
- While reset is high: cpu_run=0, h_ack=0, mem_rd=0, mem_wr=0.
- Access decode:
  - access = rd | (|wr) of the current owner.
  - done = access & (mem_ready | timeout), where timeout = (WAIT_MAX!=0) & (wcnt==WAIT_MAX).
- Mux, combinational:
  - mem_addr, mem_rd, mem_wr and mem_wdata come from the current owner.
  - If h_rd and h_wr are both set, h_wr wins and mem_rd=0.
  - Read data on timeout is all ones.
  - cpu_data and h_rdata both carry the mux read-data value.
- Owner CPU (owner=0):
  - cpu_run = cpu_en & (~access | done).
  - If cpu_en=0, all memory strobes are 0.
  - Next owner is host iff h_req & (cpu_run | ~cpu_en). A CPU access is never abandoned mid-wait.
  - On switching to host, bcnt is cleared to 0.
- Owner host (owner=1):
  - cpu_run=0; mem strobes come from the host while h_req=1, else 0.
  - h_ack = h_req & (done | ~access). A request with no strobes acks in the same cycle with no memory cycle.
  - On each h_ack, bcnt increments.
  - Next owner returns to CPU when h_req=0, or when h_ack & cpu_en & (bcnt==HOST_BURST-1).
  - With cpu_en=0 there is no burst limit.
  - The idle cycle with owner=1 and h_req=0 is a dead cycle: cpu_run=0.
- Wait counter:
  - wcnt increments each cycle access & ~done, saturating at WAIT_MAX.
  - wcnt clears on done or on an owner change.
  - bus_err <= done & ~mem_ready, i.e. it pulses the cycle after a forced completion.
- Fairness: after a host burst hits the limit, the CPU gets bus ownership for at least one completed CPU access before the host is re-granted. The host's h_req stays pending and is not acked during that time.
- Reset mid-access: an outstanding host access is dropped with no h_ack; the host must reissue it.
- A CPU wait-state stall holds cpu_run=0 and keeps mem signals stable.

Test Plan:
- CPU only, mem_ready=1, h_req=0: cpu_run=1 every cycle and mem_addr tracks cpu_addr; read 0x1234 at 0x3FFE returns cpu_data=0x1234 the same cycle.
- Host write 0x55AA to 0x0100 with h_wr=2'b11 while the CPU runs: the CPU finishes its current access, owner=1 next cycle, mem_wr=2'b11 and h_ack=1 in that cycle, cpu_run=0; owner returns to 0 two cycles later after the dead cycle.
- Host holds h_req for 10 reads with cpu_en=1 and HOST_BURST=4: acks arrive in groups of 4, each group followed by exactly one CPU access with cpu_run=1; with cpu_en=0 all 10 reads ack back-to-back.
- mem_ready held low for 3 cycles on a CPU read: cpu_run=0 for 3 cycles then 1, mem_addr stays stable, no bus_err.
- mem_ready stuck low, WAIT_MAX=15, on a host read: h_ack=1 with h_rdata=0xFFFF in the 16th cycle, and bus_err=1 for exactly one cycle after; with WAIT_MAX=0 no ack and no bus_err ever.
- Assert reset while the host is in wait state 2: h_ack never fires, owner=0, bus_err=0 and cpu_run=0 immediately; after release the CPU resumes.

Source files
------------

// File: rtl/b16_bus_arbiter.sv
// b16_bus_arbiter
//
// Shares one single-port memory bus between the b16 CPU and a second bus
// master (host, DMA engine or debug loader). The CPU is stalled through
// cpu_run while the host owns the bus or while memory inserts wait states.
// Host bursts are bounded so the CPU cannot starve. A wait-state timeout
// forces completion and reports a bus error instead of hanging the bus.
//
// Parameters:
//   l          data/address width
//   HOST_BURST completed host accesses before the CPU must get one (1..15)
//   WAIT_MAX   wait cycles before forced completion, 0 disables (0..255)
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_en                     CPU allowed to run
//   cpu_addr/rd/wr/wdata       CPU access request
//   cpu_data, cpu_run          CPU read data and run/advance enable
//   h_req/addr/rd/wr/wdata     host access request
//   h_ack, h_rdata             host completion and read data
//   mem_addr/rd/wr/wdata       memory access
//   mem_rdata, mem_ready       memory read data and completion
//   bus_err                    one-cycle pulse after a timed-out access
//   owner                      0 = CPU owns the bus, 1 = host owns it
//
// Host handshake: h_req is raised with h_addr/h_rd/h_wr/h_wdata and all of
// them are held stable until the cycle in which h_ack is high; that cycle
// completes the transfer (h_rdata valid with h_ack). A request carrying no
// strobes is acknowledged without a memory cycle. Reset drops any pending
// host access without an ack; the host must reissue it.

module b16_bus_arbiter #(
  parameter int l          = 16,
  parameter int HOST_BURST = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_en,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_rd,
  input  logic [1:0]   cpu_wr,
  input  logic [l-1:0] cpu_wdata,
  output logic [l-1:0] cpu_data,
  output logic         cpu_run,
  input  logic         h_req,
  input  logic [l-1:0] h_addr,
  input  logic         h_rd,
  input  logic [1:0]   h_wr,
  input  logic [l-1:0] h_wdata,
  output logic         h_ack,
  output logic [l-1:0] h_rdata,
  output logic [l-1:0] mem_addr,
  output logic         mem_rd,
  output logic [1:0]   mem_wr,
  output logic [l-1:0] mem_wdata,
  input  logic [l-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         bus_err,
  output logic         owner
);

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  localparam logic [3:0] BURST_LAST = 4'(HOST_BURST - 1);
  localparam logic [7:0] WAIT_LIM   = 8'(WAIT_MAX);
  localparam logic       WAIT_ON    = (WAIT_MAX != 0);

  owner_t     own_q;
  owner_t     own_nxt;
  logic [3:0] bcnt;
  logic [7:0] wcnt;
  logic       bus_err_q;

  logic         eff_rd;
  logic [1:0]   eff_wr;
  logic         access;
  logic         timeout;
  logic         done;
  logic         cpu_run_c;
  logic         h_ack_c;
  logic         burst_end;
  logic [l-1:0] rdata;

  // Strobes of whichever master currently owns the bus, already gated:
  // a halted CPU or an idle host presents no access at all.
  always_comb begin
    eff_rd = 1'b0;
    eff_wr = 2'b00;
    if (own_q == OWN_CPU) begin
      eff_rd = cpu_en & cpu_rd;
      eff_wr = cpu_en ? cpu_wr : 2'b00;
    end else begin
      // A host write takes precedence over a simultaneous host read.
      eff_wr = h_req ? h_wr : 2'b00;
      eff_rd = h_req & h_rd & ~(|h_wr);
    end
  end

  assign access  = eff_rd | (|eff_wr);
  assign timeout = WAIT_ON & (wcnt == WAIT_LIM);
  assign done    = access & (mem_ready | timeout);

  // A forced completion returns all ones rather than stale bus data.
  assign rdata = (timeout & ~mem_ready) ? {l{1'b1}} : mem_rdata;

  assign cpu_run_c = (own_q == OWN_CPU) & cpu_en & (~access | done);
  assign h_ack_c   = (own_q == OWN_HOST) & h_req & (done | ~access);
  // The burst limit only applies while the CPU actually wants to run.
  assign burst_end = h_ack_c & cpu_en & (bcnt == BURST_LAST);

  // Ownership only moves at access boundaries, so neither master's access
  // is abandoned mid-wait.
  always_comb begin
    own_nxt = own_q;
    if (own_q == OWN_CPU) begin
      if (h_req & (cpu_run_c | ~cpu_en)) own_nxt = OWN_HOST;
    end else begin
      if (~h_req | burst_end) own_nxt = OWN_CPU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q     <= OWN_CPU;
      bcnt      <= 4'd0;
      wcnt      <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      own_q     <= own_nxt;
      bus_err_q <= done & ~mem_ready;

      if ((own_q == OWN_CPU) && (own_nxt == OWN_HOST)) begin
        bcnt <= 4'd0;
      end else if (h_ack_c) begin
        bcnt <= bcnt + 4'd1;
      end

      if ((own_nxt != own_q) || done) begin
        wcnt <= 8'd0;
      end else if (access && (wcnt != WAIT_LIM)) begin
        wcnt <= wcnt + 8'd1;
      end
    end
  end

  // While reset is held, nothing may advance or touch memory.
  assign cpu_run   = cpu_run_c & ~reset;
  assign h_ack     = h_ack_c & ~reset;
  assign mem_rd    = eff_rd & ~reset;
  assign mem_wr    = eff_wr & {2{~reset}};
  assign mem_addr  = (own_q == OWN_HOST) ? h_addr : cpu_addr;
  assign mem_wdata = (own_q == OWN_HOST) ? h_wdata : cpu_wdata;
  assign cpu_data  = rdata;
  assign h_rdata   = rdata;
  assign bus_err   = bus_err_q;
  assign owner     = own_q;

endmodule

// File: tb/tb_b16_bus_arbiter.sv
module tb_b16_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic [1:0]  cpu_wr;
  logic [15:0] cpu_wdata;
  logic        h_req;
  logic [15:0] h_addr;
  logic        h_rd;
  logic [1:0]  h_wr;
  logic [15:0] h_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic [15:0] cpu_data, h_rdata, mem_addr, mem_wdata;
  logic        cpu_run, h_ack, mem_rd, bus_err, owner;
  logic [1:0]  mem_wr;

  logic [15:0] z_cpu_data, z_h_rdata, z_mem_addr, z_mem_wdata;
  logic        z_cpu_run, z_h_ack, z_mem_rd, z_bus_err, z_owner;
  logic [1:0]  z_mem_wr;

  int tests;
  int fails;
  int acks;

  // Main instance: HOST_BURST=4, WAIT_MAX=15.
  b16_bus_arbiter #(.l(16), .HOST_BURST(4), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_data(cpu_data), .cpu_run(cpu_run), .h_req(h_req), .h_addr(h_addr),
    .h_rd(h_rd), .h_wr(h_wr), .h_wdata(h_wdata), .h_ack(h_ack),
    .h_rdata(h_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bus_err(bus_err), .owner(owner)
  );

  // Timeout-disabled instance sharing the same stimulus.
  b16_bus_arbiter #(.l(16), .HOST_BURST(4), .WAIT_MAX(0)) dut_nowait (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_data(z_cpu_data), .cpu_run(z_cpu_run), .h_req(h_req),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_wdata(h_wdata),
    .h_ack(z_h_ack), .h_rdata(z_h_rdata), .mem_addr(z_mem_addr),
    .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_wdata(z_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(z_bus_err),
    .owner(z_owner)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // 1 unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    acks  = 0;
    reset = 1'b1;
    cpu_en = 1'b1; cpu_addr = 16'h3FFE; cpu_rd = 1'b1; cpu_wr = 2'b00;
    cpu_wdata = 16'h0000;
    h_req = 1'b0; h_addr = 16'h0000; h_rd = 1'b0; h_wr = 2'b00;
    h_wdata = 16'h0000;
    mem_rdata = 16'h1234; mem_ready = 1'b1;

    // Reset: outputs forced quiet even though the CPU is requesting.
    repeat (2) tick();
    #1;
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_h_ack", 32'(h_ack), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_bus_err", 32'(bus_err), 0);

    // CPU alone, zero wait states.
    reset = 1'b0;
    #1;
    chk("cpu_rd_run", 32'(cpu_run), 1);
    chk("cpu_rd_addr", 32'(mem_addr), 32'h3FFE);
    chk("cpu_rd_strobe", 32'(mem_rd), 1);
    chk("cpu_rd_data", 32'(cpu_data), 32'h1234);
    tick();
    cpu_rd = 1'b0; cpu_wr = 2'b01; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    #1;
    chk("cpu_wr_addr", 32'(mem_addr), 32'h0010);
    chk("cpu_wr_strobe", 32'(mem_wr), 32'h1);
    chk("cpu_wr_rd", 32'(mem_rd), 0);
    chk("cpu_wr_data", 32'(mem_wdata), 32'hBEEF);
    chk("cpu_wr_run", 32'(cpu_run), 1);
    tick();
    cpu_wr = 2'b00; cpu_rd = 1'b1; cpu_en = 1'b0;
    #1;
    chk("cpu_dis_run", 32'(cpu_run), 0);
    chk("cpu_dis_rd", 32'(mem_rd), 0);

    // Host write while the CPU runs (h_rd also set: write wins).
    tick();
    cpu_en = 1'b1; cpu_addr = 16'h0200;
    h_req = 1'b1; h_addr = 16'h0100; h_wr = 2'b11; h_rd = 1'b1; h_wdata = 16'h55AA;
    #1;
    chk("hw_pre_run", 32'(cpu_run), 1);
    chk("hw_pre_owner", 32'(owner), 0);
    chk("hw_pre_ack", 32'(h_ack), 0);
    chk("hw_pre_addr", 32'(mem_addr), 32'h0200);
    tick();
    #1;
    chk("hw_owner", 32'(owner), 1);
    chk("hw_addr", 32'(mem_addr), 32'h0100);
    chk("hw_wr", 32'(mem_wr), 32'h3);
    chk("hw_rd_suppressed", 32'(mem_rd), 0);
    chk("hw_wdata", 32'(mem_wdata), 32'h55AA);
    chk("hw_ack", 32'(h_ack), 1);
    chk("hw_cpu_stalled", 32'(cpu_run), 0);
    tick();
    h_req = 1'b0; h_wr = 2'b00; h_rd = 1'b0;
    #1;
    chk("hw_dead_owner", 32'(owner), 1);
    chk("hw_dead_run", 32'(cpu_run), 0);
    chk("hw_dead_wr", 32'(mem_wr), 0);
    tick();
    #1;
    chk("hw_back_owner", 32'(owner), 0);
    chk("hw_back_run", 32'(cpu_run), 1);

    // 10 host reads with cpu_en=1: groups of 4 acks, one CPU slot between.
    tick();
    h_rd = 1'b1; h_addr = 16'h0300; mem_rdata = 16'hA5A5;
    cpu_rd = 1'b1; cpu_addr = 16'h0400;
    acks = 0;
    for (int i = 0; i < 13; i++) begin
      h_req = (acks < 10);
      #1;
      chk($sformatf("burst_owner_%0d", i), 32'(owner), ((i % 5) != 0) ? 1 : 0);
      chk($sformatf("burst_ack_%0d", i), 32'(h_ack), ((i % 5) != 0) ? 1 : 0);
      chk($sformatf("burst_run_%0d", i), 32'(cpu_run), ((i % 5) == 0) ? 1 : 0);
      if ((i % 5) != 0) begin
        acks++;
        chk($sformatf("burst_rdata_%0d", i), 32'(h_rdata), 32'hA5A5);
      end
      tick();
    end
    h_req = (acks < 10);
    #1;
    chk("burst_dead_owner", 32'(owner), 1);
    chk("burst_dead_run", 32'(cpu_run), 0);
    chk("burst_dead_ack", 32'(h_ack), 0);
    tick();

    // Same 10 reads with cpu_en=0: back-to-back acks, no limit.
    cpu_en = 1'b0;
    acks = 0;
    for (int j = 0; j < 11; j++) begin
      h_req = (acks < 10);
      #1;
      chk($sformatf("nolim_owner_%0d", j), 32'(owner), (j != 0) ? 1 : 0);
      chk($sformatf("nolim_ack_%0d", j), 32'(h_ack), (j != 0) ? 1 : 0);
      chk($sformatf("nolim_run_%0d", j), 32'(cpu_run), 0);
      if (j != 0) acks++;
      tick();
    end
    h_req = (acks < 10);
    #1;
    chk("nolim_dead_owner", 32'(owner), 1);
    chk("nolim_dead_ack", 32'(h_ack), 0);
    tick();

    // CPU read with 3 wait states.
    cpu_en = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h0ABC; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ws_run_%0d", k), 32'(cpu_run), 0);
      chk($sformatf("ws_addr_%0d", k), 32'(mem_addr), 32'h0ABC);
      chk($sformatf("ws_rd_%0d", k), 32'(mem_rd), 1);
      chk($sformatf("ws_err_%0d", k), 32'(bus_err), 0);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    #1;
    chk("ws_done_run", 32'(cpu_run), 1);
    chk("ws_done_data", 32'(cpu_data), 32'h7777);
    tick();
    #1;
    chk("ws_no_err", 32'(bus_err), 0);

    // Host read against stuck memory: forced completion in the 16th cycle.
    tick();
    cpu_rd = 1'b0; h_req = 1'b1; h_rd = 1'b1; h_wr = 2'b00;
    h_addr = 16'h0200; mem_ready = 1'b0; mem_rdata = 16'h1111;
    #1;
    chk("to_pre_owner", 32'(owner), 0);
    chk("to_pre_run", 32'(cpu_run), 1);
    tick();
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (c < 16) begin
        chk($sformatf("to_wait_ack_%0d", c), 32'(h_ack), 0);
      end else begin
        chk("to_ack", 32'(h_ack), 1);
        chk("to_rdata", 32'(h_rdata), 32'hFFFF);
      end
      chk($sformatf("to_err_%0d", c), 32'(bus_err), 0);
      chk($sformatf("nt_ack_%0d", c), 32'(z_h_ack), 0);
      chk($sformatf("nt_err_%0d", c), 32'(z_bus_err), 0);
      tick();
    end
    h_req = 1'b0; h_rd = 1'b0;
    #1;
    chk("to_err_pulse", 32'(bus_err), 1);
    chk("nt_err_17", 32'(z_bus_err), 0);
    chk("nt_ack_17", 32'(z_h_ack), 0);
    tick();
    #1;
    chk("to_err_cleared", 32'(bus_err), 0);
    chk("nt_err_18", 32'(z_bus_err), 0);

    // Reset while the host sits in wait state 2.
    tick();
    h_req = 1'b1; h_rd = 1'b1; mem_ready = 1'b0;
    #1;
    chk("rm_pre_owner", 32'(owner), 0);
    tick();
    tick();
    tick();
    #1;
    chk("rm_wait_owner", 32'(owner), 1);
    chk("rm_wait_ack", 32'(h_ack), 0);
    reset = 1'b1;
    #1;
    chk("rm_owner", 32'(owner), 0);
    chk("rm_bus_err", 32'(bus_err), 0);
    chk("rm_cpu_run", 32'(cpu_run), 0);
    chk("rm_ack", 32'(h_ack), 0);
    chk("rm_mem_rd", 32'(mem_rd), 0);
    tick();
    #1;
    chk("rm_held_ack", 32'(h_ack), 0);
    chk("rm_held_owner", 32'(owner), 0);
    reset = 1'b0; h_req = 1'b0; h_rd = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 16'h0042; mem_ready = 1'b1;
    #1;
    chk("rm_resume_run", 32'(cpu_run), 1);
    chk("rm_resume_owner", 32'(owner), 0);
    chk("rm_resume_addr", 32'(mem_addr), 32'h0042);
    tick();
    #1;
    chk("rm_resume_run2", 32'(cpu_run), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
